float_adder_pipe: RTL and testbench

FLOAT_ADDER_PIPE -- requirements
Module: float_adder_pipe

---
 rtl/float_adder_pipe_pkg.sv | 14 +
 rtl/float_align_shift.sv | 38 +++
 rtl/float_adder_pipe.sv | 251 +++++++++++++++++++++++++
 tb/tb_float_adder_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_adder_pipe_pkg.sv
// Shared definitions for the pipelined floating-point adder.
package float_adder_pipe_pkg;

    // Guard, round and sticky bits carried below the significand LSB.
    localparam int GRS_W = 3;

    // Which path produces the final result word.
    typedef enum logic [1:0] {
        KIND_NORMAL,
        KIND_NAN,
        KIND_INF
    } result_kind_e;

endpackage

// File: rtl/float_align_shift.sv
// Right-shifts the smaller significand for exponent alignment, producing
// guard, round and sticky bits from everything shifted below the LSB.
module float_align_shift #(
    parameter int SIG_W = 24,
    parameter int SH_W  = 8
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [SH_W-1:0]  shift,
    output logic [SIG_W-1:0] shifted,
    output logic             guard,
    output logic             round,
    output logic             sticky
);

    localparam int EXT_W = SIG_W + 2;
    localparam logic [SH_W-1:0] SHIFT_LIMIT = SH_W'(EXT_W);

    logic [2*EXT_W-1:0] wide;

    // Shifts past the guard and round positions collapse the whole operand into sticky.
    always_comb begin
        wide    = '0;
        shifted = '0;
        guard   = 1'b0;
        round   = 1'b0;
        sticky  = 1'b0;
        if (shift >= SHIFT_LIMIT) begin
            sticky = |sig;
        end else begin
            wide    = {sig, 2'b00, {EXT_W{1'b0}}} >> shift;
            shifted = wide[2*EXT_W-1 -: SIG_W];
            guard   = wide[EXT_W+1];
            round   = wide[EXT_W];
            sticky  = |wide[EXT_W-1:0];
        end
    end

endmodule

// File: rtl/float_adder_pipe.sv
// Four-stage IEEE-754 style adder/subtractor with valid/ready handshake,
// denormal flushing, round-to-nearest-even and NaN/overflow/underflow flags.
module float_adder_pipe
    import float_adder_pipe_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     A,
    input  logic [EXP_W+FRAC_W:0]     B,
    input  logic                      op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out,
    output logic                      NaN_flag,
    output logic                      overflow_flag,
    output logic                      underflow_flag
);

    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int NORM_W = SIG_W + GRS_W;
    localparam int SUM_W  = NORM_W + 1;
    localparam int XW     = EXP_W + 2;

    localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]     EXP_ZERO  = '0;
    localparam logic [FRAC_W-1:0]    FRAC_ZERO = '0;
    localparam logic [W-1:0]         NAN_CANON = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [XW-1:0] XEXP_ZERO = '0;
    localparam logic signed [XW-1:0] XEXP_MAX  = {2'b00, EXP_ONES};

    logic advance;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // ---------------- Stage 1: unpack, classify, order by magnitude
    logic               a_sign, b_sign, x_sign, y_sign, swap;
    logic [EXP_W-1:0]   a_exp, b_exp, x_exp, y_exp;
    logic [FRAC_W-1:0]  a_frac, b_frac;
    logic               a_nan, b_nan, a_inf, b_inf;
    logic [W-2:0]       a_mag, b_mag, x_mag, y_mag;
    result_kind_e       kind1_next;
    logic               sign1_next;

    logic               s1_valid, s1_sign, s1_sub;
    result_kind_e       s1_kind;
    logic [EXP_W-1:0]   s1_exp, s1_diff;
    logic [SIG_W-1:0]   s1_xsig, s1_ysig;

    // Decode both operands, flush zero-exponent inputs and pick the larger magnitude as X.
    always_comb begin
        a_sign = A[W-1];
        a_exp  = A[W-2:FRAC_W];
        a_frac = A[FRAC_W-1:0];
        b_sign = B[W-1] ^ op;
        b_exp  = B[W-2:FRAC_W];
        b_frac = B[FRAC_W-1:0];
        a_nan  = (a_exp == EXP_ONES) && (a_frac != FRAC_ZERO);
        b_nan  = (b_exp == EXP_ONES) && (b_frac != FRAC_ZERO);
        a_inf  = (a_exp == EXP_ONES) && (a_frac == FRAC_ZERO);
        b_inf  = (b_exp == EXP_ONES) && (b_frac == FRAC_ZERO);
        a_mag  = (a_exp == EXP_ZERO) ? '0 : {a_exp, a_frac};
        b_mag  = (b_exp == EXP_ZERO) ? '0 : {b_exp, b_frac};
        swap   = b_mag > a_mag;
        x_sign = swap ? b_sign : a_sign;
        y_sign = swap ? a_sign : b_sign;
        x_mag  = swap ? b_mag : a_mag;
        y_mag  = swap ? a_mag : b_mag;
        x_exp  = x_mag[W-2:FRAC_W];
        y_exp  = y_mag[W-2:FRAC_W];
        kind1_next = KIND_NORMAL;
        sign1_next = x_sign;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
            kind1_next = KIND_NAN;
        end else if (a_inf || b_inf) begin
            kind1_next = KIND_INF;
            sign1_next = a_inf ? a_sign : b_sign;
        end
    end

    // Capture the accepted operand pair; a bubble enters when in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_kind  <= kind1_next;
            s1_sign  <= sign1_next;
            s1_sub   <= x_sign ^ y_sign;
            s1_exp   <= x_exp;
            s1_diff  <= x_exp - y_exp;
            s1_xsig  <= {|x_exp, x_mag[FRAC_W-1:0]};
            s1_ysig  <= {|y_exp, y_mag[FRAC_W-1:0]};
        end
    end

    // ---------------- Stage 2: align Y to X
    logic [SIG_W-1:0]   al_sig;
    logic               al_guard, al_round, al_sticky;

    logic               s2_valid, s2_sign, s2_sub;
    result_kind_e       s2_kind;
    logic [EXP_W-1:0]   s2_exp;
    logic [SIG_W-1:0]   s2_xsig;
    logic [NORM_W-1:0]  s2_yal;

    float_align_shift #(
        .SIG_W (SIG_W),
        .SH_W  (EXP_W)
    ) u_align (
        .sig     (s1_ysig),
        .shift   (s1_diff),
        .shifted (al_sig),
        .guard   (al_guard),
        .round   (al_round),
        .sticky  (al_sticky)
    );

    // Register the aligned smaller operand alongside the untouched larger one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_kind  <= s1_kind;
            s2_sign  <= s1_sign;
            s2_sub   <= s1_sub;
            s2_exp   <= s1_exp;
            s2_xsig  <= s1_xsig;
            s2_yal   <= {al_sig, al_guard, al_round, al_sticky};
        end
    end

    // ---------------- Stage 3: add or subtract, then normalise
    logic [SUM_W-1:0]   sum;
    logic [XW-1:0]      lz_cnt, ext_exp, exp3_next;
    logic               lz_found;
    logic [NORM_W-1:0]  norm3_next;
    logic               zero3_next, sign3_next;

    logic               s3_valid, s3_sign, s3_zero;
    result_kind_e       s3_kind;
    logic signed [XW-1:0] s3_exp;
    logic [NORM_W-1:0]  s3_norm;

    // X is never smaller than Y, so the difference cannot go negative; count
    // leading zeros to bring the leading one back to the top.
    always_comb begin
        sum = s2_sub ? ({1'b0, s2_xsig, {GRS_W{1'b0}}} - {1'b0, s2_yal})
                     : ({1'b0, s2_xsig, {GRS_W{1'b0}}} + {1'b0, s2_yal});
        lz_cnt   = '0;
        lz_found = 1'b0;
        for (int i = NORM_W - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (sum[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz_cnt = lz_cnt + XW'(1);
                end
            end
        end
        ext_exp = {2'b00, s2_exp};
        if (sum[SUM_W-1]) begin
            norm3_next = {sum[SUM_W-1:2], sum[1] | sum[0]};
            exp3_next  = ext_exp + XW'(1);
        end else begin
            norm3_next = sum[NORM_W-1:0] << lz_cnt;
            exp3_next  = ext_exp - lz_cnt;
        end
        zero3_next = (sum == '0);
        sign3_next = (zero3_next && s2_sub && (s2_kind == KIND_NORMAL)) ? 1'b0 : s2_sign;
    end

    // Register the normalised significand and its possibly out-of-range exponent.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_kind  <= s2_kind;
            s3_sign  <= sign3_next;
            s3_zero  <= zero3_next;
            s3_exp   <= exp3_next;
            s3_norm  <= norm3_next;
        end
    end

    // ---------------- Stage 4: round to nearest even and pack
    logic                 round_up;
    logic [SIG_W:0]       rounded;
    logic signed [XW-1:0] round_exp;
    logic [FRAC_W-1:0]    round_frac;
    logic [W-1:0]         out_next;
    logic                 nan_next, ovf_next, unf_next;

    // Round once, then let specials, zero, underflow and overflow override the packed value.
    always_comb begin
        round_up   = s3_norm[2] & (s3_norm[1] | s3_norm[0] | s3_norm[3]);
        rounded    = {1'b0, s3_norm[NORM_W-1:GRS_W]} + {{SIG_W{1'b0}}, round_up};
        round_exp  = s3_exp + $signed({{(XW-1){1'b0}}, rounded[SIG_W]});
        round_frac = rounded[SIG_W] ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
        out_next   = {s3_sign, round_exp[EXP_W-1:0], round_frac};
        nan_next   = 1'b0;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        case (s3_kind)
            KIND_NAN: begin
                out_next = NAN_CANON;
                nan_next = 1'b1;
            end
            KIND_INF: begin
                out_next = {s3_sign, EXP_ONES, FRAC_ZERO};
            end
            default: begin
                if (s3_zero) begin
                    out_next = {s3_sign, {(W-1){1'b0}}};
                end else if (s3_exp <= XEXP_ZERO) begin
                    out_next = {s3_sign, {(W-1){1'b0}}};
                    unf_next = 1'b1;
                end else if (round_exp >= XEXP_MAX) begin
                    out_next = {s3_sign, EXP_ONES, FRAC_ZERO};
                    ovf_next = 1'b1;
                end
            end
        endcase
    end

    // Output register; holds its contents while the consumer is not ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out            <= '0;
            NaN_flag       <= 1'b0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
        end else if (advance) begin
            out_valid      <= s3_valid;
            out            <= out_next;
            NaN_flag       <= nan_next;
            overflow_flag  <= ovf_next;
            underflow_flag <= unf_next;
        end
    end

endmodule

// File: tb/tb_float_adder_pipe.sv
// Self-checking bench for float_adder_pipe: directed corner cases plus a
// randomized stream scored against a double-precision reference model.
module tb_float_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_w;
    logic        nan_flag;
    logic        ovf_flag;
    logic        unf_flag;

    int          vectors = 0;
    int          miscompares = 0;
    int          popped = 0;
    logic [34:0] expq[$];
    logic        prev_stall = 1'b0;
    logic [35:0] prev_obs = '0;
    logic        obs_in_ready;
    logic        obs_out_valid;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    float_adder_pipe #(
        .EXP_W  (8),
        .FRAC_W (23)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .A              (a_in),
        .B              (b_in),
        .op             (op),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out            (out_w),
        .NaN_flag       (nan_flag),
        .overflow_flag  (ovf_flag),
        .underflow_flag (unf_flag)
    );

    function automatic logic [63:0] to_dbl(logic s, logic [7:0] e, logic [22:0] f);
        if (e == 8'd0) return {s, 63'd0};
        return {s, 11'(e) + 11'd896, f, 29'd0};
    endfunction

    // Reference: exact-enough double sum, then single-precision RNE with flush rules.
    function automatic logic [34:0] ref_add(logic [31:0] av, logic [31:0] bv, logic o);
        logic        sa, sb, nan_a, nan_b, inf_a, inf_b, up;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb, f;
        logic [28:0] rem;
        logic [23:0] fr;
        logic [63:0] d;
        real         sum;
        int          es;
        sa = av[31]; ea = av[30:23]; fa = av[22:0];
        sb = bv[31] ^ o; eb = bv[30:23]; fb = bv[22:0];
        nan_a = (ea == 8'hFF) && (fa != 0);
        nan_b = (eb == 8'hFF) && (fb != 0);
        inf_a = (ea == 8'hFF) && (fa == 0);
        inf_b = (eb == 8'hFF) && (fb == 0);
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) return {32'h7FC00000, 3'b100};
        if (inf_a) return {sa, 8'hFF, 23'd0, 3'b000};
        if (inf_b) return {sb, 8'hFF, 23'd0, 3'b000};
        sum = $bitstoreal(to_dbl(sa, ea, fa)) + $bitstoreal(to_dbl(sb, eb, fb));
        d = $realtobits(sum);
        if (d[62:0] == 63'd0) return {d[63], 31'd0, 3'b000};
        es = int'(d[62:52]) - 896;
        if (es <= 0) return {d[63], 31'd0, 3'b001};
        f   = d[51:29];
        rem = d[28:0];
        up  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && f[0]);
        fr  = {1'b0, f} + 24'(up);
        if (fr[23]) es++;
        if (es >= 255) return {d[63], 8'hFF, 23'd0, 3'b010};
        return {d[63], es[7:0], fr[22:0], 3'b000};
    endfunction

    function automatic logic [31:0] rand_op(int base);
        int          sel;
        logic [7:0]  e;
        logic [22:0] f;
        sel = $urandom_range(0, 15);
        f   = 23'($urandom);
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'hFF;
        else if (sel == 2) e = 8'hFE;
        else if (sel == 3) e = 8'd1;
        else               e = 8'(base + $urandom_range(0, 28));
        if ($urandom_range(0, 3) == 0) f[10:0] = '0;
        if ((sel == 1) && ($urandom_range(0, 1) == 0)) f = '0;
        return {1'($urandom), e, f};
    endfunction

    // One handshake cycle: drive at negedge, sample just after, score accepts and results.
    task automatic run_cycle(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                             input logic o, input logic ordy, output logic accepted);
        logic [34:0] got;
        logic [34:0] exp_v;
        @(negedge clk);
        in_valid  = iv;
        a_in      = av;
        b_in      = bv;
        op        = o;
        out_ready = ordy;
        #1;
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        got = {out_w, nan_flag, ovf_flag, unf_flag};
        if (prev_stall) begin
            vectors++;
            if ({out_valid, got} !== prev_obs) begin
                miscompares++;
                $display("[TB] FAIL stall_hold: got %h required %h", {out_valid, got}, prev_obs);
            end
        end
        vectors++;
        if (in_ready !== !(out_valid && !ordy)) begin
            miscompares++;
            $display("[TB] FAIL in_ready: got %b required %b", in_ready, !(out_valid && !ordy));
        end
        prev_stall = out_valid && !ordy;
        prev_obs   = {out_valid, got};
        accepted   = iv && in_ready;
        if (accepted) expq.push_back(ref_add(av, bv, o));
        if (out_valid && ordy) begin
            vectors++;
            popped++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_result: got %h required none", got);
            end else begin
                exp_v = expq.pop_front();
                if (got !== exp_v) begin
                    miscompares++;
                    $display("[TB] FAIL result: got %h required %h", got, exp_v);
                end
            end
        end
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 60 && expq.size() > 0; i++) run_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending required 0", expq.size());
        end
    endtask

    // Reset clears outputs, and a pair offered during reset is never accepted.
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a_in = 32'h3F800000; b_in = 32'h3F800000; op = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if ({out_valid, out_w, nan_flag, ovf_flag, unf_flag} !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h required 0", {out_valid, out_w, nan_flag, ovf_flag, unf_flag});
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_accept: got out_valid %b required 0", out_valid);
            end
        end
    endtask

    // Single operations into an empty pipe: exact latency and known results.
    task automatic test_directed();
        logic [31:0] da[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                                32'h7F7FFFFF, 32'h00000001, 32'h80000000, 32'h7F800000,
                                32'h3F800000, 32'h00800000, 32'h7F800001, 32'hFF800000};
        logic [31:0] db[12] = '{32'h40000000, 32'h3F800000, 32'h33800000, 32'hFF800000,
                                32'h7F7FFFFF, 32'h80000000, 32'h80000000, 32'h3F800000,
                                32'h00800000, 32'h00C00000, 32'h3F800000, 32'h7F800000};
        logic        dop[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [34:0] dexp[12] = '{{32'h40400000, 3'b000}, {32'h00000000, 3'b000},
                                  {32'h3F800000, 3'b000}, {32'h7FC00000, 3'b100},
                                  {32'h7F800000, 3'b010}, {32'h00000000, 3'b000},
                                  {32'h80000000, 3'b000}, {32'h7F800000, 3'b000},
                                  {32'h3F800000, 3'b000}, {32'h80000000, 3'b001},
                                  {32'h7FC00000, 3'b100}, {32'hFF800000, 3'b000}};
        prev_stall = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a_in = da[k]; b_in = db[k]; op = dop[k]; out_ready = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL directed_ready[%0d]: got %b required 1", k, in_ready);
            end
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                vectors++;
                if (c < 4) begin
                    if (out_valid !== 1'b0) begin
                        miscompares++;
                        $display("[TB] FAIL directed_early[%0d] cycle %0d: got out_valid %b required 0", k, c, out_valid);
                    end
                end else if ({out_valid, out_w, nan_flag, ovf_flag, unf_flag} !== {1'b1, dexp[k]}) begin
                    miscompares++;
                    $display("[TB] FAIL directed[%0d]: got %b %h required 1 %h", k, out_valid,
                             {out_w, nan_flag, ovf_flag, unf_flag}, dexp[k]);
                end
            end
        end
    endtask

    // Eight back-to-back pairs with the consumer stalling for three cycles mid-stream.
    task automatic test_back_to_back();
        logic [31:0] va[8];
        logic [31:0] vb[8];
        logic        vo[8];
        int          idx = 0;
        int          start_pop;
        int          stalls = 0;
        logic        acc, ordy;
        for (int i = 0; i < 8; i++) begin
            int base = $urandom_range(100, 150);
            va[i] = {1'($urandom), 8'(base + $urandom_range(0, 5)), 23'($urandom)};
            vb[i] = {1'($urandom), 8'(base + $urandom_range(0, 5)), 23'($urandom)};
            vo[i] = 1'($urandom);
        end
        prev_stall = 1'b0;
        start_pop  = popped;
        for (int cyc = 0; cyc < 30; cyc++) begin
            ordy = !(cyc >= 5 && cyc <= 7);
            if (idx < 8) run_cycle(1'b1, va[idx], vb[idx], vo[idx], ordy, acc);
            else         run_cycle(1'b0, 32'd0, 32'd0, 1'b0, ordy, acc);
            if (acc) idx++;
            if (!ordy) begin
                vectors++;
                if (obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL stall_ready cycle %0d: got in_ready %b out_valid %b required 0 1",
                             cyc, obs_in_ready, obs_out_valid);
                end else begin
                    stalls++;
                end
            end
        end
        drain();
        vectors++;
        if (idx != 8 || (popped - start_pop) != 8 || stalls != 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got accepted %0d returned %0d stalls %0d required 8 8 3",
                     idx, popped - start_pop, stalls);
        end
    endtask

    // Random operands with random source gaps and consumer back-pressure.
    task automatic test_random();
        logic acc;
        int   base;
        prev_stall = 1'b0;
        for (int i = 0; i < 800; i++) begin
            base = $urandom_range(1, 220);
            run_cycle(($urandom_range(0, 3) != 0), rand_op(base), rand_op(base), 1'($urandom),
                      ($urandom_range(0, 3) != 0), acc);
        end
        drain();
    endtask

    // Reset with results in flight: nothing stale may emerge afterwards.
    task automatic test_reset_flush();
        logic acc;
        prev_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 32'h3F800000 + 32'(i), 32'h40000000, 1'b0, 1'b1, acc);
            vectors++;
            if (acc !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL flush_accept[%0d]: got %b required 1", i, acc);
            end
        end
        run_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
        run_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if ({out_valid, out_w, nan_flag, ovf_flag, unf_flag} !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL flush_reset: got %h required 0", {out_valid, out_w, nan_flag, ovf_flag, unf_flag});
        end
        rst = 1'b0;
        expq.delete();
        prev_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
            vectors++;
            if (obs_out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL flush_stale cycle %0d: got out_valid %b required 0", i, obs_out_valid);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; op = 1'b0; out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
